// File: rtl/mxv_pkg.sv
// Shared types and width helpers for the mxv_mac_seq matrix-vector MAC sequencer.
package mxv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } mxv_state_e;

    // Row result holds a K-term sum of N x N signed products without overflow.
    function automatic int res_width(input int n, input int k);
        return 2 * n + k - 1;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mxv_mac_seq_if.sv
// Matrix element stream and row-result stream of mxv_mac_seq.
interface mxv_mac_seq_if
    import mxv_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 3,
    parameter int M = 3
);
    localparam int W  = res_width(N, K);
    localparam int RW = idx_width(M);

    logic                 g_valid;
    logic signed [N-1:0]  g_data;
    logic                 g_ready;
    logic                 res_valid;
    logic signed [W-1:0]  res_data;
    logic [RW-1:0]        res_row;
    logic                 res_ready;

    modport master (
        output g_valid, g_data, res_ready,
        input  g_ready, res_valid, res_data, res_row
    );

    modport slave (
        input  g_valid, g_data, res_ready,
        output g_ready, res_valid, res_data, res_row
    );

endinterface

// File: rtl/mxv_acc_unit.sv
// Signed multiply-accumulate; clr restarts the sum with the current product.
module mxv_acc_unit #(
    parameter int N = 8,
    parameter int W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [W-1:0] acc
);
    logic signed [2*N-1:0] prod;
    logic signed [W-1:0]   base;

    assign prod = a * b;
    assign base = clr ? '0 : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + W'(prod);
        end
    end

endmodule

// File: rtl/mxv_mac_seq.sv
// Matrix-vector product sequencer: vector E in local storage, matrix streamed row-major.
// Optional MXV_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
//
// state | meaning
// IDLE  | waiting for start; vector writes accepted
// RUN   | accepting matrix beats of the current row
// OUT   | row result presented until res_ready
module mxv_mac_seq
    import mxv_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 3,
    parameter int M = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    e_wr_en,
    input  logic [idx_width(K)-1:0] e_wr_addr,
    input  logic signed [N-1:0]     e_wr_data,
    input  logic                    start,
    mxv_mac_seq_if.slave            bus,
    output logic                    busy,
    output logic                    done
`ifdef MXV_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    localparam int W  = res_width(N, K);
    localparam int AW = idx_width(K);
    localparam int RW = idx_width(M);
    localparam logic [AW-1:0] COL_LAST = AW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
    localparam logic [AW:0]   K_LIM    = (AW + 1)'(K);

    mxv_state_e          state;
    logic [AW-1:0]       col;
    logic [RW-1:0]       row;
    logic signed [N-1:0] e_mem [K];
    logic signed [W-1:0] acc;
    logic                beat;
    logic                start_ok;

    assign beat          = (state == RUN) && bus.g_valid;
    assign start_ok      = (state == IDLE) && start;
    assign bus.g_ready   = (state == RUN);
    assign bus.res_valid = (state == OUT);
    assign bus.res_data  = acc;
    assign bus.res_row   = row;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start_ok) begin
                    state <= RUN;
                    col   <= '0;
                    row   <= '0;
                end
                RUN: if (beat) begin
                    if (col == COL_LAST) begin
                        col   <= '0;
                        state <= OUT;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                OUT: if (bus.res_ready) begin
                    if (row == ROW_LAST) begin
                        row   <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        row   <= row + 1'b1;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes only land in IDLE, so a write alongside start is visible to the first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) e_mem[i] <= '0;
        end else if (e_wr_en && (state == IDLE) && ({1'b0, e_wr_addr} < K_LIM)) begin
            e_mem[e_wr_addr] <= e_wr_data;
        end
    end

    mxv_acc_unit #(.N(N), .W(W)) u_acc (
        .clk (clk),
        .rst (rst),
        .en  (beat),
        .clr (col == '0),
        .a   (bus.g_data),
        .b   (e_mem[col]),
        .acc (acc)
    );

`ifdef MXV_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cnt <= '0;
        end else if (((state == RUN && !bus.g_valid) || (state == OUT && !bus.res_ready))
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mxv_mac_seq.md
MXV_MAC_SEQ -- requirements
Module: mxv_mac_seq

Interface
REQ-001 Parameter N, default 8, signed element width of matrix and vector entries.
REQ-002 Parameter K, default 3, vector dimension (matrix columns).
REQ-003 Parameter M, default 3, matrix rows.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have ports e_wr_en (input, 1), e_wr_addr (input, clog2(K)) and e_wr_data (input, N, signed), which write one vector entry per cycle.
REQ-007 The block SHALL have port start, input, 1 bit; a one-cycle pulse begins a matrix-vector product.
REQ-008 The block SHALL have ports g_valid (input, 1), g_data (input, N, signed) and g_ready (output, 1), forming a row-major matrix element stream.
REQ-009 The block SHALL have ports res_valid (output, 1), res_data (output, 2N+K-1, signed), res_row (output, clog2(M)) and res_ready (input, 1), forming the row-result stream.
REQ-010 The block SHALL have ports busy (output, 1) and done (output, 1), where done is a one-cycle completion pulse.

Function
REQ-011 The block SHALL have FSM states IDLE, RUN and OUT.
- IDLE->RUN on start.
- RUN->OUT on acceptance of element col=K-1.
- OUT->RUN on result handshake when row<M-1.
- OUT->IDLE on result handshake when row=M-1.
REQ-012 A beat is accepted when g_valid&&g_ready; g_ready SHALL be 1 only in RUN.
REQ-013 On an accepted beat, acc SHALL become (col==0 ? 0 : acc) + g_data*E[col], sign-extended to 2N+K-1 bits; no overflow is possible.
REQ-014 col SHALL increment per accepted beat and wrap K-1->0; row SHALL increment on each result handshake.
REQ-015 res_valid SHALL be 1 exactly in OUT; res_data=acc and res_row=row SHALL be held stable until res_ready.
REQ-016 Row latency SHALL be one cycle: res_valid rises in the cycle after the beat with col=K-1 is accepted.
REQ-017 done SHALL pulse for one cycle in the cycle after the final result handshake; busy=(state!=IDLE).
REQ-018 start while busy SHALL be ignored.
REQ-019 e_wr_en while busy SHALL be ignored; e_wr_en concurrent with start is accepted, and the write takes effect before the first beat.
REQ-020 e_wr_addr>=K SHALL be ignored.
REQ-021 g_valid outside RUN SHALL have no effect; a gap in g_valid SHALL hold col and acc.

Reset
REQ-022 rst SHALL force the following state: FSM=IDLE, col=0, row=0, acc=0, E[*]=0, res_valid=0, g_ready=0, done=0, busy=0.
REQ-023 rst asserted mid-operation SHALL abort the operation with no result or done emitted; rst has priority over all other inputs.

Configuration
REQ-024 With `MXV_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits): +1 per RUN cycle with g_valid=0 and per OUT cycle with res_ready=0, saturating at 16'hFFFF, cleared by rst and by an accepted start.
REQ-025 Without MXV_STALL_CNT_EN, the port and counter SHALL NOT exist, and behaviour is otherwise identical.

Structure
REQ-026 A package mxv_pkg SHALL hold the state enum (IDLE/RUN/OUT) and the function for result width 2N+K-1.
REQ-027 One sub-module, mxv_acc_unit, SHALL contain the signed multiply-accumulate with clear-on-first; the FSM, counters and vector storage stay in mxv_mac_seq.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Basic product: load E={-38,-91,47}, start, stream G rows {29,74,-39},{67,-71,56},{75,-45,34} back-to-back with res_ready=1 -> results -9669 (row0), 6547 (row1), 2843 (row2); done one cycle after the last result.
- Row latency: with no gaps -> res_valid one cycle after the third beat of each row; g_ready=0 while res_valid=1.
- Backpressure: hold res_ready=0 for 5 cycles on row1 -> res_data=6547 and res_row=1 stable; no beats accepted; with MXV_STALL_CNT_EN, stall_cnt=5.
- Ignored inputs: start and e_wr_en during RUN -> no restart, E unchanged, results still -9669/6547/2843.
- Reset mid-run: rst after 2 beats of row1 -> all outputs 0, IDLE, E cleared; a new run with E reloaded gives correct results.
- Extremes: N=8, all G=-128, all E=-128 -> each row 49152 with no overflow.
